// File: rtl/mem16x8_arb.sv
`default_nettype none
// ============================================================================
// Module   : mem16x8_arb
// Brief    : Two-port round-robin arbiter and fill sequencer for the 16x8
//            register-file memory, with a two-stage read-return pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module mem16x8_arb #(
    parameter logic [7:0] FILL           = 8'h00,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    output logic       busy,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    output logic [7:0] mem_data,
    input  logic [7:0] mem_out
);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_state_nxt;
    logic [3:0] r_cnt;
    logic       r_ptr;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_busy;
    logic       w_mem_we;
    logic [3:0] w_mem_addr;
    logic [7:0] w_mem_data;
    logic       r_s1_valid;
    logic       r_s1_port;
    logic       r_rvalid0;
    logic       r_rvalid1;
    logic [7:0] r_rdata0;
    logic [7:0] r_rdata1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (r_cnt == 4'd15) w_state_nxt = ST_RUN;
            ST_RUN:   if (clr)            w_state_nxt = ST_CLEAR;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    // Grants and memory drive; the cycle that samples clr is kept grant-free.
    always_comb begin
        w_gnt0     = 1'b0;
        w_gnt1     = 1'b0;
        w_busy     = 1'b0;
        w_mem_we   = 1'b0;
        w_mem_addr = 4'h0;
        w_mem_data = 8'h00;
        case (r_state)
            ST_CLEAR: begin
                w_busy     = 1'b1;
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt;
                w_mem_data = FILL;
            end
            ST_RUN: begin
                if (!clr) begin
                    if (req0 && (!req1 || !r_ptr)) begin
                        w_gnt0 = 1'b1;
                    end else if (req1) begin
                        w_gnt1 = 1'b1;
                    end
                end
                if (w_gnt0) begin
                    w_mem_we   = we0;
                    w_mem_addr = addr0;
                    w_mem_data = wdata0;
                end else if (w_gnt1) begin
                    w_mem_we   = we1;
                    w_mem_addr = addr1;
                    w_mem_data = wdata1;
                end
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Sweep counter idles at zero in RUN so every sweep starts from address 0.
    always_ff @(posedge clk) begin
        if (rst || (r_state == ST_RUN)) begin
            r_cnt <= 4'h0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_gnt0) begin
            r_ptr <= 1'b1;
        end else if (w_gnt1) begin
            r_ptr <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_port  <= 1'b0;
        end else begin
            r_s1_valid <= (w_gnt0 && !we0) || (w_gnt1 && !we1);
            r_s1_port  <= w_gnt1;
        end
    end

    // mem_out carries the data for the address driven one cycle earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= 8'h00;
            r_rdata1  <= 8'h00;
        end else begin
            r_rvalid0 <= r_s1_valid && !r_s1_port;
            r_rvalid1 <= r_s1_valid && r_s1_port;
            if (r_s1_valid && !r_s1_port) r_rdata0 <= mem_out;
            if (r_s1_valid && r_s1_port)  r_rdata1 <= mem_out;
        end
    end

    assign busy     = w_busy;
    assign gnt0     = w_gnt0;
    assign gnt1     = w_gnt1;
    assign mem_we   = w_mem_we;
    assign mem_addr = w_mem_addr;
    assign mem_data = w_mem_data;
    assign rvalid0  = r_rvalid0;
    assign rvalid1  = r_rvalid1;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem16x8_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem16x8_arb
// Brief    : Directed bench for mem16x8_arb with a memory model and a
//            transaction-level reference checked every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem16x8_arb;

    localparam logic [7:0] FILL_V = 8'hA5;

    logic       clk;
    logic       rst, clr, req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       busy, gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [7:0] rdata0, rdata1, mem_data, mem_out;
    logic [3:0] mem_addr;

    logic       nc_rst, nc_req0, nc_we0, nc_busy, nc_gnt0, nc_gnt1;
    logic       nc_rvalid0, nc_rvalid1, nc_mem_we;
    logic [3:0] nc_addr0, nc_mem_addr;
    logic [7:0] nc_wdata0, nc_rdata0, nc_rdata1, nc_mem_data;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    mem16x8_arb #(.FILL(FILL_V), .CLEAR_ON_RESET(1'b1)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
    );

    mem16x8_arb #(.FILL(8'h00), .CLEAR_ON_RESET(1'b0)) u_dut_nc (
        .clk(clk), .rst(nc_rst), .clr(1'b0), .busy(nc_busy),
        .req0(nc_req0), .req1(1'b0), .we0(nc_we0), .we1(1'b0),
        .addr0(nc_addr0), .addr1(4'h0), .wdata0(nc_wdata0), .wdata1(8'h00),
        .gnt0(nc_gnt0), .gnt1(nc_gnt1), .rvalid0(nc_rvalid0), .rvalid1(nc_rvalid1),
        .rdata0(nc_rdata0), .rdata1(nc_rdata1),
        .mem_we(nc_mem_we), .mem_addr(nc_mem_addr), .mem_data(nc_mem_data), .mem_out(8'h00)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: write on the edge, registered read of the current address.
    logic [7:0] mem_arr [16];
    always @(posedge clk) begin
        if (mem_we) mem_arr[mem_addr] <= mem_data;
        mem_out <= mem_arr[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: sweep countdown, last-served pointer, shadow memory, read queue.
    typedef struct {
        int         port;
        logic [7:0] data;
        int         due;
    } rd_t;

    bit         m_known = 1'b0;
    int         m_clear_left = 0;
    int         m_prio = 0;
    logic [7:0] m_mem [16];
    logic [7:0] m_rdata [2];
    rd_t        m_q [$];

    function automatic logic p_we(int p);          return (p == 1) ? we1 : we0;       endfunction
    function automatic logic [3:0] p_addr(int p);  return (p == 1) ? addr1 : addr0;   endfunction
    function automatic logic [7:0] p_wdata(int p); return (p == 1) ? wdata1 : wdata0; endfunction

    function automatic int model_grant();
        if (!m_known || m_clear_left > 0 || clr) return -1;
        if (req0 && req1) return m_prio;
        if (req0) return 0;
        if (req1) return 1;
        return -1;
    endfunction

    task automatic model_step();
        int g;
        if (m_q.size() > 0 && m_q[0].due == cyc) begin
            m_rdata[m_q[0].port] = m_q[0].data;
            void'(m_q.pop_front());
        end
        if (rst) begin
            m_known      = 1'b1;
            m_clear_left = 16;
            m_prio       = 0;
            m_q.delete();
            m_rdata[0]   = 8'h00;
            m_rdata[1]   = 8'h00;
        end else if (m_known) begin
            g = model_grant();
            if (m_clear_left > 0) begin
                m_mem[16 - m_clear_left] = FILL_V;
                m_clear_left--;
            end else if (clr) begin
                m_clear_left = 16;
            end else if (g >= 0) begin
                if (p_we(g)) m_mem[p_addr(g)] = p_wdata(g);
                else         m_q.push_back('{port: g, data: m_mem[p_addr(g)], due: cyc + 2});
                m_prio = 1 - g;
            end
        end
        cyc++;
    endtask

    always @(posedge clk) model_step();

    int         e_g;
    logic       e_pulse, e_we;
    int         e_port;
    logic [3:0] e_addr;
    logic [7:0] e_data, e_rd0, e_rd1;

    always @(negedge clk) begin
        if (m_known) begin
            e_g     = model_grant();
            e_pulse = (m_q.size() > 0) && (m_q[0].due == cyc);
            e_port  = e_pulse ? m_q[0].port : -1;
            e_rd0   = (e_port == 0) ? m_q[0].data : m_rdata[0];
            e_rd1   = (e_port == 1) ? m_q[0].data : m_rdata[1];
            if (m_clear_left > 0) begin
                e_we = 1'b1; e_addr = 4'(16 - m_clear_left); e_data = FILL_V;
            end else if (e_g >= 0) begin
                e_we = p_we(e_g); e_addr = p_addr(e_g); e_data = p_wdata(e_g);
            end else begin
                e_we = 1'b0; e_addr = 4'h0; e_data = 8'h00;
            end
            chk("busy",     busy,     m_clear_left > 0);
            chk("gnt0",     gnt0,     e_g == 0);
            chk("gnt1",     gnt1,     e_g == 1);
            chk("mem_we",   mem_we,   e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_data", mem_data, e_data);
            chk("rvalid0",  rvalid0,  e_port == 0);
            chk("rvalid1",  rvalid1,  e_port == 1);
            chk("rdata0",   rdata0,   e_rd0);
            chk("rdata1",   rdata1,   e_rd1);
        end
    end

    task automatic issue(input int p, input logic w, input logic [3:0] a, input logic [7:0] d,
                         output int waited);
        waited = -1;
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if ((p == 0) ? gnt0 : gnt1) begin
                waited = i;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        if (p == 0) req0 = 1'b0; else req1 = 1'b0;
        chk("grant_seen", waited >= 0, 1'b1);
    endtask

    task automatic wait_rv(input int p, output logic [7:0] d, output int lat);
        lat = -1;
        d   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if ((p == 0) ? rvalid0 : rvalid1) begin
                d   = (p == 0) ? rdata0 : rdata1;
                lat = i;
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rvalid_seen", lat >= 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected the run to finish");
        $fatal(1);
    end

    initial begin
        int         w, lat, busy_cnt, c0, c1;
        logic [7:0] d;
        rst = 1'b1; clr = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 4'h0; addr1 = 4'h0; wdata0 = 8'h00; wdata1 = 8'h00;
        nc_rst = 1'b1; nc_req0 = 1'b0; nc_we0 = 1'b0; nc_addr0 = 4'h0; nc_wdata0 = 8'h00;

        // Reset fill sweep
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            chk("fill_addr", mem_addr, busy_cnt);
            chk("fill_we", mem_we, 1'b1);
            busy_cnt++;
            @(posedge clk); #1;
        end
        chk("fill_len", busy_cnt, 16);
        @(posedge clk); #1;
        issue(0, 1'b0, 4'd0, 8'h00, w);
        wait_rv(0, d, lat);
        chk("fill_rd_a0", d, 8'hA5);
        chk("rd_latency", lat, 1);
        issue(1, 1'b0, 4'd15, 8'h00, w);
        wait_rv(1, d, lat);
        chk("fill_rd_a15", d, 8'hA5);

        // Single-port write then read
        issue(0, 1'b1, 4'd7, 8'h3C, w);
        chk("wr_gnt_wait", w, 0);
        issue(0, 1'b0, 4'd7, 8'h00, w);
        chk("rd_gnt_wait", w, 0);
        wait_rv(0, d, lat);
        chk("wr_rd_data", d, 8'h3C);
        chk("wr_rd_latency", lat, 1);

        // Contention
        issue(0, 1'b1, 4'd1, 8'h11, w);
        issue(1, 1'b1, 4'd2, 8'h22, w);
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        c0 = 0; c1 = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 6) chk("cont_gnt0", gnt0, (i % 2) == 0);
            if (rvalid0 && rdata0 == 8'h11) c0++;
            if (rvalid1 && rdata1 == 8'h22) c1++;
            @(posedge clk); #1;
            if (i == 5) begin req0 = 1'b0; req1 = 1'b0; end
        end
        chk("cont_rv0_cnt", c0, 3);
        chk("cont_rv1_cnt", c1, 3);

        // Clear mid-traffic
        issue(0, 1'b1, 4'd4, 8'h77, w);
        issue(0, 1'b0, 4'd4, 8'h00, w);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        wait_rv(0, d, lat);
        chk("clr_rd_data", d, 8'h77);
        chk("clr_rd_latency", lat, 0);
        chk("clr_busy", busy, 1'b1);
        issue(1, 1'b0, 4'd4, 8'h00, w);
        chk("clr_grant_wait", w, 15);
        wait_rv(1, d, lat);
        chk("clr_refill_data", d, 8'hA5);

        // Reset with a read in flight
        issue(0, 1'b0, 4'd7, 8'h00, w);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_no_rvalid0", rvalid0, 1'b0);
            chk("rst_rdata0", rdata0, 8'h00);
            @(posedge clk); #1;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk("rst_sweep_done", busy, 1'b0);
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd0;
        @(negedge clk);
        chk("rst_ptr_gnt0", gnt0, 1'b1);
        chk("rst_ptr_gnt1", gnt1, 1'b0);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        chk("rst_ptr_next_gnt1", gnt1, 1'b1);
        @(posedge clk); #1;
        req1 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end

        // CLEAR_ON_RESET = 0 instance
        nc_req0 = 1'b1; nc_we0 = 1'b1; nc_addr0 = 4'd9; nc_wdata0 = 8'h5A;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nc_rst = 1'b0;
        @(negedge clk);
        chk("nc_busy", nc_busy, 1'b0);
        chk("nc_gnt0", nc_gnt0, 1'b1);
        chk("nc_mem_addr", nc_mem_addr, 4'd9);
        chk("nc_mem_data", nc_mem_data, 8'h5A);
        @(posedge clk); #1;
        nc_req0 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
